dmem_dma_arbiter: RTL
=====================

Name: dmem_dma_arbiter

Overview:
- Shares the single DMA-side port of a core's local DMEM between one write-command stream and one read-command stream.
- Both streams come from the AXI RAM write/read interface adapters.
- Grants whole bursts, caps the grant length so neither side starves, and buffers read data in a small response FIFO.
- The DMEM is never read and written in the same cycle.
- Sits between the AXI RAM interface adapters and the core's DMEM DMA port.

Parameters:
- DATA_WIDTH, 64, data bus width.
- ADDR_WIDTH, 16, DMEM byte-address width.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- ID_WIDTH, 8, read ID width.
- MAX_BURST_BEATS, 16, maximum beats per grant while the other side is waiting.
- INTERLEAVE, 0, 1 = alternate every beat when both sides are pending.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- wr_cmd_addr  in  ADDR_WIDTH  write beat address.
- wr_cmd_data  in  DATA_WIDTH  write data.
- wr_cmd_strb  in  STRB_WIDTH  byte strobes.
- wr_cmd_last  in  1  last beat of the write burst.
- wr_cmd_valid  in  1  write beat valid.
- wr_cmd_ready  out  1  write beat accepted.
- rd_cmd_id  in  ID_WIDTH  read ID.
- rd_cmd_addr  in  ADDR_WIDTH  read beat address.
- rd_cmd_last  in  1  last beat of the read burst.
- rd_cmd_valid  in  1  read beat valid.
- rd_cmd_ready  out  1  read beat accepted.
- rd_resp_id  out  ID_WIDTH  response ID.
- rd_resp_data  out  DATA_WIDTH  response data.
- rd_resp_last  out  1  response last beat.
- rd_resp_valid  out  1  response valid.
- rd_resp_ready  in  1  response consumer ready.
- mem_en  out  1  DMEM port enable.
- mem_wen  out  STRB_WIDTH  DMEM byte write enables.
- mem_addr  out  ADDR_WIDTH  DMEM address.
- mem_wr_data  out  DATA_WIDTH  DMEM write data.
- mem_rd_data  in  DATA_WIDTH  DMEM read data, valid one cycle after a read.
- grant_state  out  2  current owner: 00 idle, 01 write, 10 read.

Behaviour:
- FSM states: IDLE, WRITE, READ. Register last_grant; reset value READ, so write wins the first tie.
- The effective owner is computed combinationally:
  - In WRITE or READ, the owner is the state.
  - In IDLE with one side valid, the owner is that side.
  - In IDLE with both sides valid, the owner is the opposite of last_grant.
  - A beat issues in the same cycle IDLE sees a request; there is no bubble.
- Write beat rules:
  - A write beat issues when owner=WRITE and wr_cmd_valid.
  - wr_cmd_ready = (owner==WRITE).
  - mem_en=1, mem_wen=wr_cmd_strb, mem_addr=wr_cmd_addr, mem_wr_data=wr_cmd_data.
- Read beat rules:
  - A read beat issues when owner=READ, rd_cmd_valid and credit_ok.
  - credit_ok = (fifo_count + inflight) < 4, where inflight is the 1-bit register "read issued last cycle".
  - rd_cmd_ready = owner==READ && credit_ok.
  - mem_en=1, mem_wen=0, mem_addr=rd_cmd_addr.
- Port driving: mem_en=0 and mem_wen=0 in every cycle without an issued beat; the port is never read and written in the same cycle.
- Beat counter:
  - Width $clog2(MAX_BURST_BEATS+1).
  - Increments per issued beat of the current grant.
  - Clears on every grant change.
- End of grant: on the same clock edge as the terminating beat, next state=IDLE, last_grant=owner, counter cleared. Any of these terminates the grant:
  - The beat carries last.
  - The counter reaches MAX_BURST_BEATS with the other side valid.
  - INTERLEAVE=1 and the other side is valid.
- Otherwise the grant is held, including cycles where the owner's valid is low or read credit is exhausted. A grant never switches mid-burst except through the cap or INTERLEAVE.
- Read response path:
  - ID and last are registered at issue.
  - At the next edge, {id, last, mem_rd_data} is pushed into a 4-entry FIFO.
  - rd_resp_valid = FIFO non-empty; a pop occurs on valid && ready.
  - Latency: beat issued in cycle N → rd_resp_valid in cycle N+2.
  - One beat per cycle is sustained with rd_resp_ready held high.
  - The credit check guarantees no overflow; a push and pop in the same cycle leaves the count unchanged.
- Reset (rst=0 at a clock edge):
  - State=IDLE, last_grant=READ, counter=0, inflight=0, FIFO emptied.
  - All outputs 0: ready, valid, mem_en, mem_wen, grant_state.
  - Reset mid-burst drops partial bursts and in-flight reads; the adapters are reset in the same domain.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - Grant encoding localparams GNT_IDLE=2'b00, GNT_WRITE=2'b01, GNT_READ=2'b10.
  - RESP_FIFO_DEPTH=4.
- One sub-module, dmem_resp_fifo: synchronous 4-entry FIFO with the same active-low reset, exposing count to the credit logic.

Test Plan:
- Write-only burst: 4 beats at 0x0100, last on beat 4 → mem_wen=strb for 4 consecutive cycles, grant_state 01 then 00.
- Read-only burst: 8 beats, ID=0x5A, ready held high → 8 responses in cycles N+2..N+9, rd_resp_last on beat 8 only, data matches memory.
- Simultaneous arrival from IDLE (write 32 beats, read 4 beats): write gets 16 beats, then read gets 4, then the remaining 16 writes; no cycle with mem_en and a read overlapping a write.
- Backpressure: rd_resp_ready=0 during a 10-beat read → exactly 4 beats issued, rd_cmd_ready low afterwards; release ready → all 10 delivered in order, none lost.
- INTERLEAVE=1 with both sides streaming → grant_state alternates 01/10 on every beat.
- Reset asserted mid read burst with 2 FIFO entries → next cycle rd_resp_valid=0, grant_state=00, mem_en=0; a fresh write after reset is granted first.

Source files
------------

// File: rtl/dmem_dma_arbiter_pkg.sv
// Shared definitions for the DMEM DMA-port arbiter: grant encodings,
// response FIFO depth and the arbiter state type.
package dmem_arb_pkg;

    localparam logic [1:0] GNT_IDLE  = 2'b00;
    localparam logic [1:0] GNT_WRITE = 2'b01;
    localparam logic [1:0] GNT_READ  = 2'b10;

    localparam int unsigned RESP_FIFO_DEPTH = 4;

    // State encodings match the grant encodings so the owner can be
    // presented on grant_state without translation.
    typedef enum logic [1:0] {
        ST_IDLE  = GNT_IDLE,
        ST_WRITE = GNT_WRITE,
        ST_READ  = GNT_READ
    } arb_state_t;

    // The side that did not hold the previous grant.
    function automatic arb_state_t other_side(input arb_state_t s);
        return (s == ST_WRITE) ? ST_READ : ST_WRITE;
    endfunction

endpackage

// File: rtl/dmem_dma_arbiter_if.sv
// Command/response bundle between the AXI RAM adapters and the arbiter.
// slave: arbiter side; master: adapter side.
interface dmem_dma_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8
) ();

    logic [ADDR_WIDTH-1:0] wr_cmd_addr;
    logic [DATA_WIDTH-1:0] wr_cmd_data;
    logic [STRB_WIDTH-1:0] wr_cmd_strb;
    logic                  wr_cmd_last;
    logic                  wr_cmd_valid;
    logic                  wr_cmd_ready;

    logic [ID_WIDTH-1:0]   rd_cmd_id;
    logic [ADDR_WIDTH-1:0] rd_cmd_addr;
    logic                  rd_cmd_last;
    logic                  rd_cmd_valid;
    logic                  rd_cmd_ready;

    logic [ID_WIDTH-1:0]   rd_resp_id;
    logic [DATA_WIDTH-1:0] rd_resp_data;
    logic                  rd_resp_last;
    logic                  rd_resp_valid;
    logic                  rd_resp_ready;

    modport slave (
        input  wr_cmd_addr, wr_cmd_data, wr_cmd_strb, wr_cmd_last, wr_cmd_valid,
        output wr_cmd_ready,
        input  rd_cmd_id, rd_cmd_addr, rd_cmd_last, rd_cmd_valid,
        output rd_cmd_ready,
        output rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid,
        input  rd_resp_ready
    );

    modport master (
        output wr_cmd_addr, wr_cmd_data, wr_cmd_strb, wr_cmd_last, wr_cmd_valid,
        input  wr_cmd_ready,
        output rd_cmd_id, rd_cmd_addr, rd_cmd_last, rd_cmd_valid,
        input  rd_cmd_ready,
        input  rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid,
        output rd_resp_ready
    );

endinterface

// File: rtl/dmem_dma_arbiter_resp_fifo.sv
// Small synchronous FIFO for read responses. Count is exported so the
// arbiter can hold back reads that would not fit.
module dmem_resp_fifo
    import dmem_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 73,
    parameter int unsigned DEPTH = RESP_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       not_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && (count_q != CNT_W'(DEPTH));
    assign do_pop    = pop && (count_q != '0);
    assign not_empty = (count_q != '0);
    assign count     = count_q;
    assign pop_data  = store[rd_ptr];

    // Entry storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop keeps the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_dma_arbiter.sv
// Arbitrates the DMEM DMA port between a write-command stream and a
// read-command stream. Grants whole bursts, caps a grant when the other
// side is waiting, and returns read data through a small response FIFO.
module dmem_dma_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH        = 8,
    parameter int unsigned MAX_BURST_BEATS = 16,
    parameter int unsigned INTERLEAVE      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_dma_arbiter_if.slave     cmd,
    output logic                  mem_en,
    output logic [STRB_WIDTH-1:0] mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [1:0]            grant_state
);

    localparam int unsigned CNT_W      = $clog2(MAX_BURST_BEATS + 1);
    localparam int unsigned FIFO_CNT_W = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int unsigned SUM_W      = FIFO_CNT_W + 1;
    localparam int unsigned RESP_W     = ID_WIDTH + 1 + DATA_WIDTH;

    arb_state_t state_q, state_d;
    arb_state_t last_grant_q, last_grant_d;
    arb_state_t owner;

    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  inflight_q;
    logic [ID_WIDTH-1:0]   resp_id_q;
    logic                  resp_last_q;

    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [SUM_W-1:0]      outstanding;
    logic                  credit_ok;
    logic                  fifo_valid;
    logic [RESP_W-1:0]     resp_word;

    logic wr_issue, rd_issue, issue;
    logic beat_last, other_valid, cap_hit, end_grant;

    // Reads in flight or buffered must never exceed the FIFO depth.
    assign outstanding = SUM_W'(fifo_count) + SUM_W'(inflight_q);
    assign credit_ok   = (outstanding < SUM_W'(RESP_FIFO_DEPTH));
    assign cap_hit     = (beat_cnt_q >= CNT_W'(MAX_BURST_BEATS - 1));

    // Owner selection, beat issue, DMEM port drive and next-state decision.
    always_comb begin
        owner        = ST_IDLE;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        mem_en       = 1'b0;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wr_data  = '0;

        // Owner is forced idle while reset is held so no beat is issued.
        if (rst) begin
            case (state_q)
                ST_WRITE: owner = ST_WRITE;
                ST_READ:  owner = ST_READ;
                default: begin
                    if (cmd.wr_cmd_valid && cmd.rd_cmd_valid) begin
                        owner = other_side(last_grant_q);
                    end else if (cmd.wr_cmd_valid) begin
                        owner = ST_WRITE;
                    end else if (cmd.rd_cmd_valid) begin
                        owner = ST_READ;
                    end
                end
            endcase
        end

        wr_issue    = (owner == ST_WRITE) && cmd.wr_cmd_valid;
        rd_issue    = (owner == ST_READ) && cmd.rd_cmd_valid && credit_ok;
        issue       = wr_issue || rd_issue;
        beat_last   = wr_issue ? cmd.wr_cmd_last : cmd.rd_cmd_last;
        other_valid = (owner == ST_WRITE) ? cmd.rd_cmd_valid : cmd.wr_cmd_valid;
        end_grant   = issue && (beat_last ||
                                (cap_hit && other_valid) ||
                                ((INTERLEAVE != 0) && other_valid));

        cmd.wr_cmd_ready = (owner == ST_WRITE);
        cmd.rd_cmd_ready = (owner == ST_READ) && credit_ok;
        grant_state      = owner;

        if (wr_issue) begin
            mem_en      = 1'b1;
            mem_wen     = cmd.wr_cmd_strb;
            mem_addr    = cmd.wr_cmd_addr;
            mem_wr_data = cmd.wr_cmd_data;
        end else if (rd_issue) begin
            mem_en   = 1'b1;
            mem_addr = cmd.rd_cmd_addr;
        end

        if (owner != ST_IDLE) begin
            state_d = owner;
        end
        if (issue && (beat_cnt_q != CNT_W'(MAX_BURST_BEATS))) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (end_grant) begin
            state_d      = ST_IDLE;
            last_grant_d = owner;
            beat_cnt_d   = '0;
        end
    end

    // Arbiter state, burst counter and read-issue pipeline stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ST_READ;
            beat_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            resp_id_q    <= '0;
            resp_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            inflight_q   <= rd_issue;
            if (rd_issue) begin
                resp_id_q   <= cmd.rd_cmd_id;
                resp_last_q <= cmd.rd_cmd_last;
            end
        end
    end

    dmem_resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({resp_id_q, resp_last_q, mem_rd_data}),
        .pop       (cmd.rd_resp_ready),
        .pop_data  (resp_word),
        .not_empty (fifo_valid),
        .count     (fifo_count)
    );

    assign cmd.rd_resp_valid = fifo_valid;
    assign cmd.rd_resp_id    = resp_word[RESP_W-1 -: ID_WIDTH];
    assign cmd.rd_resp_last  = resp_word[DATA_WIDTH];
    assign cmd.rd_resp_data  = resp_word[DATA_WIDTH-1:0];

endmodule
